// File: rtl/shift_lane_pkg.sv
// Shared constants, FSM state type and a reference lane shift for the
// multi-cycle right shifter.
package shift_lane_pkg;
  localparam int LANE_W    = 12;
  localparam int LANES     = 8;
  localparam int DATA_W    = LANE_W * LANES;
  localparam int SHIFT_W   = 3;
  localparam int MAX_SHIFT = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Reference right shift by n lanes with fill entering at the top lane.
  // Counts above MAX_SHIFT return the data untouched, matching the
  // error path of the shifter.
  function automatic logic [DATA_W-1:0] lane_shift_right_ref(
    input logic [DATA_W-1:0]  data,
    input logic [SHIFT_W-1:0] n,
    input logic [LANE_W-1:0]  fill
  );
    logic [DATA_W-1:0] r;
    r = data;
    if (int'(n) <= MAX_SHIFT) begin
      for (int i = 0; i < MAX_SHIFT; i++) begin
        if (i < int'(n)) r = {fill, r[DATA_W-1:LANE_W]};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/lane_step_right.sv
// One-lane right step: every lane takes its upper neighbour, the top lane
// takes the fill value. Only the upper LANES-1 lanes of the word are needed,
// so only those are brought in.
module lane_step_right #(
  parameter int LANE_W = 12,
  parameter int LANES  = 8
) (
  input  logic [(LANES-1)*LANE_W-1:0] data,
  input  logic [LANE_W-1:0]           fill,
  output logic [LANES*LANE_W-1:0]     y
);
  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      if (k == LANES - 1) begin : g_top
        assign y[k*LANE_W +: LANE_W] = fill;
      end else begin : g_mid
        // data[0] is the original lane 1, so lane k picks data lane k
        assign y[k*LANE_W +: LANE_W] = data[k*LANE_W +: LANE_W];
      end
    end
  endgenerate
endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle lane-granular right shifter: one lane per clock through a
// single step stage, valid/ready on both sides, no request overlap.
module shift_right_seq
  import shift_lane_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [LANE_W-1:0] fill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_err
);
  localparam logic [SHIFT_W-1:0] MAX_C = SHIFT_W'(MAX_SHIFT);
  localparam logic [SHIFT_W-1:0] ONE_C = SHIFT_W'(1);

  state_t              state, state_nx;
  logic [SHIFT_W-1:0]  count;
  logic [DATA_W-1:0]   data_q;
  logic [LANE_W-1:0]   fill_q;
  logic                err_q;
  logic [DATA_W-1:0]   step_y;
  logic                accept;
  logic                bad_shift;

  // Handshake flags are pure decodes of the state register, so neither
  // ready nor valid depends combinationally on the other side's inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = data_q;
  assign out_err   = err_q;
  assign accept    = in_valid & in_ready;
  assign bad_shift = (shift > MAX_C);

  lane_step_right #(
    .LANE_W(LANE_W),
    .LANES (LANES)
  ) u_step (
    .data(data_q[DATA_W-1:LANE_W]),
    .fill(fill_q),
    .y   (step_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: zero and illegal counts skip straight to DONE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nx = (bad_shift || shift == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == ONE_C) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture at accept, step one lane per SHIFT cycle, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      data_q <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      count  <= shift;
      data_q <= in;
      fill_q <= fill;
      err_q  <= bad_shift;
    end else if (state == SHIFT) begin
      count  <= count - ONE_C;
      data_q <= step_y;
    end
  end
endmodule

// File: tb/tb_shift_right_seq.sv
// Directed and random bench for shift_right_seq with a latency/queue level
// model and a per-cycle compare process.
module tb_shift_right_seq;
  import shift_lane_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [95:0] din = '0;
  logic [2:0]  shift = '0;
  logic [11:0] fill = '0;
  logic        in_ready, out_valid, out_err;
  logic [95:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_right_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .shift    (shift),
    .fill     (fill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .out_err  (out_err)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected result: plain shift of the whole word by 12*n bits, top n lanes
  // overwritten with fill; illegal counts pass data through.
  function automatic logic [95:0] model(input logic [95:0] d, input int n, input logic [11:0] f);
    logic [95:0] r;
    if (n > 5) return d;
    r = d >> (12 * n);
    for (int k = 8 - n; k < 8; k++) r[12*k +: 12] = f;
    return r;
  endfunction

  // Model: m_left = -1 idle, >0 cycles until result, 0 result on offer
  int          m_left = -1;
  int          m_acc = 0, m_outs = 0, m_lost = 0, d_outs = 0;
  logic [95:0] m_out = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_left >= 0) m_lost <= m_lost + 1;
      m_left <= -1;
      m_out  <= '0;
      m_err  <= 1'b0;
    end else begin
      if (out_valid && out_ready) d_outs <= d_outs + 1;
      if (m_left < 0) begin
        if (in_valid) begin
          m_acc  <= m_acc + 1;
          m_out  <= model(din, int'(shift), fill);
          m_err  <= (shift > 3'd5);
          m_left <= (shift > 3'd5) ? 0 : int'(shift);
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (out_ready) begin
        m_left <= -1;
        m_outs <= m_outs + 1;
      end
    end
  end

  // Per-cycle compare; out is only meaningful outside the shifting phase
  always @(negedge clk) begin
    chk("cyc in_ready", in_ready, m_left < 0);
    chk("cyc out_valid", out_valid, m_left == 0);
    if (m_left <= 0) begin
      chk("cyc out", dout, m_out);
      chk("cyc out_err", out_err, m_err);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded time limit %0d", 3000000);
    $fatal(1, "watchdog");
  end

  // Directed request with out_ready held high; inputs scrambled after accept
  task automatic req(input string nm, input logic [95:0] d, input logic [2:0] s,
                     input logic [11:0] f, input logic [95:0] eo, input logic ee,
                     input int elat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    chk({nm, " ready before"}, in_ready, 1);
    din = d; shift = s; fill = f; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; din = ~d; fill = ~f; shift = 3'd1;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " out"}, dout, eo);
    chk({nm, " err"}, out_err, ee);
    @(posedge clk); #1;
    chk({nm, " in_ready after"}, in_ready, 1);
    chk({nm, " out_valid after"}, out_valid, 0);
  endtask

  localparam logic [95:0] T1_IN = 96'h777666555444333222111000;

  initial begin
    bit          acc;
    int          g;
    logic [95:0] held;
    logic [95:0] bp_exp;

    // Pin the model and the package reference against hand values
    chk("model pin s2", model(T1_IN, 2, 12'hABC), 96'hABCABC777666555444333222);
    chk("model pin s5", model(T1_IN, 5, 12'h000), 96'h000000000000000777666555);
    chk("pkg ref s2", lane_shift_right_ref(T1_IN, 3'd2, 12'hABC), 96'hABCABC777666555444333222);
    chk("pkg ref s7", lane_shift_right_ref(96'h1, 3'd7, 12'hFFF), 96'h1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out", dout, 96'h0);
    chk("reset out_err", out_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic shifts
    req("t1 s2", T1_IN, 3'd2, 12'hABC, 96'hABCABC777666555444333222, 1'b0, 3);
    req("t2 s0", T1_IN, 3'd0, 12'hFFF, T1_IN, 1'b0, 1);
    req("t2 s5", T1_IN, 3'd5, 12'h000, 96'h000000000000000777666555, 1'b0, 6);

    // Illegal counts, then a legal one clears the error
    req("t3 s6", 96'h1, 3'd6, 12'h123, 96'h1, 1'b1, 1);
    req("t3 s7", 96'h1, 3'd7, 12'h456, 96'h1, 1'b1, 1);
    req("t3 s1", 96'h1, 3'd1, 12'h005, 96'h005000000000000000000000, 1'b0, 2);

    // Backpressure with a competing request held on the input
    bp_exp = 96'h9E59E59E50123456789ABCDE;
    out_ready = 1'b0;
    din = 96'h0123456789ABCDEF01234567; shift = 3'd3; fill = 12'h9E5; in_valid = 1'b1;
    @(posedge clk); #1;
    din = {3{32'hFFFF_FFFF}}; shift = 3'd0; fill = 12'h000;
    g = 1;
    while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
    chk("t4 latency", g, 4);
    held = dout;
    chk("t4 out", held, bp_exp);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4 hold out", dout, bp_exp);
      chk("t4 hold valid", out_valid, 1);
      chk("t4 hold err", out_err, 0);
      chk("t4 hold in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4 after valid", out_valid, 0);
    chk("t4 after in_ready", in_ready, 1);
    chk("t4 after out held", dout, bp_exp);

    // Reset in the second SHIFT cycle of a 4-lane request
    din = T1_IN; shift = 3'd4; fill = 12'h111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5 busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("t5 rst out_valid", out_valid, 0);
    chk("t5 rst in_ready", in_ready, 1);
    chk("t5 rst out", dout, 96'h0);
    chk("t5 rst out_err", out_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req("t5 after", T1_IN, 3'd2, 12'hABC, 96'hABCABC777666555444333222, 1'b0, 3);

    // Random regression; per-cycle compare does the checking
    for (int i = 0; i < 2000; i++) begin
      din = {$urandom, $urandom, $urandom};
      shift = 3'($urandom_range(0, 7));
      fill = 12'($urandom_range(0, 4095));
      in_valid = 1'b1;
      acc = 1'b0;
      g = 0;
      while (!acc && g < 100) begin
        acc = in_ready;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        g++;
      end
      if (!acc) chk("rand accept timeout", 0, 1);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end

    // Drain and account for every accepted request
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("accept/output balance", m_acc, m_outs + m_lost);
    chk("dut handshake count", d_outs, m_outs);
    chk("lost by reset", m_lost, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
